// File: rtl/matrix_operand_loader_if.sv
// Bundle between the element stream source, the operand loader and the multiplier.
// The master side feeds elements and accepts frames; the slave side is the loader.
interface matrix_operand_loader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS_A     = 2,
   parameter int COLS_A     = 2,
   parameter int COLS_B     = 2
);
   logic [DATA_WIDTH-1:0]                          s_data;
   logic                                           s_valid;
   logic                                           s_last;
   logic                                           s_ready;
   logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0]  a;
   logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0]  b;
   logic                                           mat_valid;
   logic                                           mat_ready;
   logic                                           frame_err;

   modport master (
      output s_data, s_valid, s_last, mat_ready,
      input  s_ready, a, b, mat_valid, frame_err
   );

   modport slave (
      input  s_data, s_valid, s_last, mat_ready,
      output s_ready, a, b, mat_valid, frame_err
   );
endinterface

// File: rtl/matrix_operand_loader.sv
// Assembles a serial element stream into operand A then operand B for the matrix
// multiplier, holding the completed pair until the consumer takes it.
module matrix_operand_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS_A     = 2,
   parameter int COLS_A     = 2,
   parameter int COLS_B     = 2
) (
   input logic                    clk,
   input logic                    rst,
   matrix_operand_loader_if.slave bus
);
   localparam int NA   = ROWS_A * COLS_A;
   localparam int NB   = COLS_A * COLS_B;
   localparam int MAXN = (NA > NB) ? NA : NB;
   localparam int IW   = $clog2(MAXN + 1);
   localparam logic [IW-1:0] LAST_A = IW'(NA - 1);
   localparam logic [IW-1:0] LAST_B = IW'(NB - 1);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} state_t;

   state_t                                         r_state;
   state_t                                         w_nextState;
   logic [IW-1:0]                                  r_index;
   logic [IW-1:0]                                  w_nextIndex;
   logic                                           r_frameErr;
   logic                                           w_frameErrNext;
   logic                                           w_accept;
   logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0]  r_a;
   logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0]  r_b;

   // Ready depends only on registered state, so no path from mat_ready or s_valid.
   assign w_accept      = bus.s_valid && (r_state != FULL);
   assign bus.s_ready   = (r_state != FULL);
   assign bus.mat_valid = (r_state == FULL);
   assign bus.frame_err = r_frameErr;
   assign bus.a         = r_a;
   assign bus.b         = r_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= LOAD_A;
         r_index    <= '0;
         r_frameErr <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_index    <= w_nextIndex;
         r_frameErr <= w_frameErrNext;
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_nextIndex    = r_index;
      w_frameErrNext = 1'b0;
      unique case (r_state)
         LOAD_A: begin
            if (w_accept) begin
               if (bus.s_last) begin
                  w_nextState    = LOAD_A;
                  w_nextIndex    = '0;
                  w_frameErrNext = 1'b1;
               end else if (r_index == LAST_A) begin
                  w_nextState = LOAD_B;
                  w_nextIndex = '0;
               end else begin
                  w_nextIndex = r_index + 1'b1;
               end
            end
         end
         LOAD_B: begin
            if (w_accept) begin
               // A missing s_last on the final element still delivers the frame.
               if (r_index == LAST_B) begin
                  w_nextState    = FULL;
                  w_nextIndex    = '0;
                  w_frameErrNext = !bus.s_last;
               end else if (bus.s_last) begin
                  w_nextState    = LOAD_A;
                  w_nextIndex    = '0;
                  w_frameErrNext = 1'b1;
               end else begin
                  w_nextIndex = r_index + 1'b1;
               end
            end
         end
         FULL: begin
            if (bus.mat_ready) begin
               w_nextState = LOAD_A;
               w_nextIndex = '0;
            end
         end
         default: begin
            w_nextState = LOAD_A;
            w_nextIndex = '0;
         end
      endcase
   end

   // Operand storage is never cleared except by reset; aborted elements stay written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
      end else if (w_accept) begin
         if (r_state == LOAD_A) begin
            for (int k = 0; k < NA; k++) begin
               if (r_index == IW'(k)) r_a[k / COLS_A][k % COLS_A] <= bus.s_data;
            end
         end else if (r_state == LOAD_B) begin
            for (int k = 0; k < NB; k++) begin
               if (r_index == IW'(k)) r_b[k / COLS_B][k % COLS_B] <= bus.s_data;
            end
         end
      end
   end
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader: directed frames plus randomized
// frames, gaps, framing errors and backpressure checked against a frame-position model.
module tb_matrix_operand_loader;
   localparam int DW = 8;
   localparam int RA = 2;
   localparam int CA = 2;
   localparam int CB = 2;
   localparam int NA = RA * CA;
   localparam int NB = CA * CB;
   localparam int NF = NA + NB;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   int   modelA [RA][CA];
   int   modelB [CA][CB];
   int   pos;
   bit   expErr;
   bit   expFull;

   matrix_operand_loader_if #(.DATA_WIDTH(DW), .ROWS_A(RA), .COLS_A(CA), .COLS_B(CB)) bus ();

   matrix_operand_loader #(.DATA_WIDTH(DW), .ROWS_A(RA), .COLS_A(CA), .COLS_B(CB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      for (int r = 0; r < RA; r++) for (int c = 0; c < CA; c++) modelA[r][c] = 0;
      for (int r = 0; r < CA; r++) for (int c = 0; c < CB; c++) modelB[r][c] = 0;
      pos     = 0;
      expErr  = 1'b0;
      expFull = 1'b0;
   endtask

   task automatic checkMatrices(input string tag);
      logic [RA-1:0][CA-1:0][DW-1:0] expA;
      logic [CA-1:0][CB-1:0][DW-1:0] expB;
      for (int r = 0; r < RA; r++) for (int c = 0; c < CA; c++) expA[r][c] = DW'(modelA[r][c]);
      for (int r = 0; r < CA; r++) for (int c = 0; c < CB; c++) expB[r][c] = DW'(modelB[r][c]);
      checkOutput({tag, "_a"}, 64'(bus.a), 64'(expA));
      checkOutput({tag, "_b"}, 64'(bus.b), 64'(expB));
   endtask

   // Sends one element after 'gap' idle cycles; called and returns at a falling edge.
   task automatic applyStimulus(input logic [DW-1:0] d, input bit last, input int gap);
      int waited;
      for (int g = 0; g < gap; g++) begin
         bus.s_valid = 1'b0;
         @(negedge clk);
      end
      waited = 0;
      while (!bus.s_ready && waited < 20) begin
         bus.s_valid = 1'b0;
         @(negedge clk);
         waited++;
      end
      if (!bus.s_ready) checkOutput("readyTimeout", 64'(bus.s_ready), 64'(1));
      bus.s_data  = d;
      bus.s_last  = last;
      bus.s_valid = 1'b1;
      @(posedge clk);
      if (pos < NA) modelA[pos / CA][pos % CA] = int'(d);
      else          modelB[(pos - NA) / CB][(pos - NA) % CB] = int'(d);
      if (pos == NF - 1) begin
         expFull = 1'b1;
         expErr  = !last;
         pos     = 0;
      end else if (last) begin
         expFull = 1'b0;
         expErr  = 1'b1;
         pos     = 0;
      end else begin
         expErr = 1'b0;
         pos++;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      checkOutput("frameErr", 64'(bus.frame_err), 64'(expErr));
      checkOutput("matValid", 64'(bus.mat_valid), 64'(expFull));
      checkOutput("sReady", 64'(bus.s_ready), 64'(!expFull));
      checkMatrices("elem");
   endtask

   // Holds the full frame for 'bp' cycles with s_valid asserted, then hands it off.
   task automatic handoff(input int bp);
      for (int i = 0; i < bp; i++) begin
         bus.s_valid   = 1'b1;
         bus.s_data    = DW'($urandom_range(0, 255));
         bus.mat_ready = 1'b0;
         @(negedge clk);
         checkOutput("bpReady", 64'(bus.s_ready), 64'(0));
         checkOutput("bpValid", 64'(bus.mat_valid), 64'(1));
         checkMatrices("bp");
      end
      bus.s_valid   = 1'b0;
      bus.mat_ready = 1'b1;
      @(negedge clk);
      bus.mat_ready = 1'b0;
      expFull = 1'b0;
      expErr  = 1'b0;
      checkOutput("handoffValid", 64'(bus.mat_valid), 64'(0));
      checkOutput("handoffReady", 64'(bus.s_ready), 64'(1));
      checkOutput("handoffErr", 64'(bus.frame_err), 64'(0));
   endtask

   initial begin
      int lastAt;
      int sel;
      total = 0;
      bad   = 0;
      resetModel();
      bus.s_data    = '0;
      bus.s_valid   = 1'b0;
      bus.s_last    = 1'b0;
      bus.mat_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstReady", 64'(bus.s_ready), 64'(1));
      checkOutput("rstValid", 64'(bus.mat_valid), 64'(0));
      checkOutput("rstErr", 64'(bus.frame_err), 64'(0));
      checkOutput("rstA", 64'(bus.a), 64'(0));
      checkOutput("rstB", 64'(bus.b), 64'(0));

      // Basic continuous frame 1..8.
      for (int i = 1; i <= NF; i++) applyStimulus(DW'(i), i == NF, 0);
      checkOutput("basicA", 64'(bus.a), 64'h0403_0201);
      checkOutput("basicB", 64'(bus.b), 64'h0807_0605);
      handoff(5);

      // Gapped input, one idle cycle between elements.
      for (int i = 1; i <= NF; i++) applyStimulus(DW'(i + 32), i == NF, 1);
      checkOutput("gapA", 64'(bus.a), 64'h2423_2221);
      checkOutput("gapB", 64'(bus.b), 64'h2827_2625);
      handoff(0);

      // Early s_last on the third element, then a clean frame 9..16.
      for (int i = 1; i <= 3; i++) applyStimulus(DW'(i + 64), i == 3, 0);
      @(negedge clk);
      checkOutput("earlyErrGone", 64'(bus.frame_err), 64'(0));
      for (int i = 9; i <= 16; i++) applyStimulus(DW'(i), i == 16, 0);
      checkOutput("cleanA", 64'(bus.a), 64'h0c0b_0a09);
      checkOutput("cleanB", 64'(bus.b), 64'h100f_0e0d);
      handoff(0);

      // Missing s_last on the final element.
      for (int i = 1; i <= NF; i++) applyStimulus(DW'(i + 96), 1'b0, 0);
      handoff(1);

      // Randomized frames with gaps, framing errors and backpressure.
      for (int f = 0; f < 40; f++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 60)      lastAt = NF - 1;
         else if (sel < 80) lastAt = int'($urandom_range(0, NF - 2));
         else               lastAt = -1;
         for (int i = 0; i < NF; i++) begin
            applyStimulus(DW'($urandom_range(0, 255)), i == lastAt, int'($urandom_range(0, 2)));
            if (i == lastAt && i != NF - 1) break;
         end
         if (expFull) handoff(int'($urandom_range(0, 3)));
         else @(negedge clk);
      end

      // Asynchronous reset between clock edges after six elements.
      for (int i = 1; i <= 6; i++) applyStimulus(DW'(i + 16), 1'b0, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      resetModel();
      checkOutput("asyncReady", 64'(bus.s_ready), 64'(1));
      checkOutput("asyncValid", 64'(bus.mat_valid), 64'(0));
      checkOutput("asyncErr", 64'(bus.frame_err), 64'(0));
      checkOutput("asyncA", 64'(bus.a), 64'(0));
      checkOutput("asyncB", 64'(bus.b), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= NF; i++) applyStimulus(DW'(i), i == NF, 0);
      checkOutput("postRstA", 64'(bus.a), 64'h0403_0201);
      checkOutput("postRstB", 64'(bus.b), 64'h0807_0605);
      handoff(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
